stopwatch_bcd_counter: RTL
==========================

// Module: stopwatch_bcd_counter
// PURPOSE
//   Stopwatch time-keeping stage directly downstream of the 10 ms RTC timer.
//   Consumes the timer's o_base_tick and counts hundredths, seconds and minutes in BCD.
//   Has start/stop, clear and lap-freeze controls.
//   Drives the timer's i_timerenb, and drives BCD digits to the display mux stage.
// PARAMETERS
//   EDGE_MODE  1   1: every toggle of i_base_tick = 10 ms step; 0: rising edge only
//   MIN_MAX    59  last minute value before wrap to zero (integer, 1..99)
// PORTS
//   i_sclk        in   1  system clock, all state on rising edge
//   i_reset_n     in   1  asynchronous active-low reset
//   i_base_tick   in   1  tick from RTC timer; synchronous to i_sclk
//   i_start_stop  in   1  1-cycle pulse: toggle run/stop
//   i_clear       in   1  1-cycle pulse: zero count, force stop
//   i_lap         in   1  1-cycle pulse: freeze/unfreeze display while running
//   o_timerenb    out  1  enable to RTC timer; 1 while running
//   o_cs_bcd      out  8  hundredths, two BCD digits 00..99
//   o_sec_bcd     out  8  seconds, two BCD digits 00..59
//   o_min_bcd     out  8  minutes, two BCD digits 00..MIN_MAX
//   o_running     out  1  1 in RUNNING or LAP
//   o_lap_active  out  1  1 in LAP (display frozen)
//   o_rollover    out  1  1-cycle pulse when count wraps MIN_MAX:59.99 -> 00:00.00
// BEHAVIOUR
//   Reset (async, immediate): all outputs 0, live count 0, state STOPPED, tick_d <= 0.
//   Tick detect:
//     - tick_d registers i_base_tick every cycle.
//     - step = (i_base_tick ^ tick_d) when EDGE_MODE=1.
//     - step = (i_base_tick & ~tick_d) when EDGE_MODE=0.
//   Count updates on the i_sclk edge ending the cycle in which step=1.
//   A step is taken only in RUNNING or LAP; in STOPPED it is discarded, never queued.
//   BCD arithmetic:
//     - Each digit counts 0..9.
//     - cs wraps 99->00 and carries to seconds.
//     - Seconds wrap 59->00 and carry to minutes.
//     - Minutes wrap MIN_MAX->00.
//     - Full wrap pulses o_rollover for exactly the cycle after the update.
//     - Binary values never appear on the outputs.
//   FSM states: STOPPED, RUNNING, LAP.
//     - STOPPED + start_stop -> RUNNING
//     - RUNNING + start_stop -> STOPPED
//     - RUNNING + lap        -> LAP; latch current live count into display regs
//     - LAP + lap            -> RUNNING; display shows live count again
//     - LAP + start_stop     -> STOPPED; display shows live count
//     - STOPPED + lap        -> ignored
//   Priority within one cycle: clear > start_stop > lap.
//     - clear: live+display count 0, state STOPPED, o_rollover 0, any step that cycle dropped.
//     - start_stop and lap together: lap ignored.
//   Display outputs: live count in STOPPED/RUNNING; latched lap value in LAP.
//     Live count keeps advancing underneath the frozen display.
//   o_timerenb = o_running, registered from state.
//     RTC timer stops ticking while STOPPED; count resumes from held value on restart.
//   Step coinciding with start_stop out of RUNNING: step is applied, then state STOPPED.
//   Step in the same cycle as start_stop from STOPPED: step discarded.
// TESTING
//   1. Hold i_reset_n=0 with clock running -> all outputs 0, o_timerenb=0.
//      Release, pulse i_lap -> still STOPPED, outputs 0.
//   2. EDGE_MODE=1: pulse start_stop, apply 150 toggles of i_base_tick ->
//      min/sec/cs = 00/01/50 (8'h00/8'h01/8'h50), o_running=1, o_timerenb=1.
//   3. Count to 00:59.99, one more toggle -> 01:00.00.
//      MIN_MAX=1: count to 01:59.99, one toggle -> 00:00.00, o_rollover high exactly 1 cycle.
//   4. Running at 00:00.25: pulse i_lap, apply 30 toggles ->
//      outputs hold 00:00.25, o_lap_active=1.
//      Pulse i_lap -> outputs 00:00.55 next cycle, o_lap_active=0.
//   5. Running at 00:03.07: assert i_clear and i_start_stop same cycle ->
//      outputs 0, o_running=0; further toggles leave count at 0.
//   6. Running at 00:00.40: drop i_reset_n between clock edges ->
//      outputs 0 before next i_sclk edge; after release state STOPPED.
//      EDGE_MODE=0 run: 10 full tick periods -> cs=8'h10.

Source files
------------

// File: rtl/stopwatch_bcd_counter.sv
// BCD stopwatch (cs/sec/min) driven by the RTC base tick, with start/stop, clear and lap freeze.
// Count and outputs update one i_sclk edge after the step; no backpressure, steps while stopped are dropped.
module stopwatch_bcd_counter #(
  parameter int EDGE_MODE = 1,
  parameter int MIN_MAX   = 59
) (
  input  logic       i_sclk,
  input  logic       i_reset_n,
  input  logic       i_base_tick,
  input  logic       i_start_stop,
  input  logic       i_clear,
  input  logic       i_lap,
  output logic       o_timerenb,
  output logic [7:0] o_cs_bcd,
  output logic [7:0] o_sec_bcd,
  output logic [7:0] o_min_bcd,
  output logic       o_running,
  output logic       o_lap_active,
  output logic       o_rollover
);

  localparam logic [1:0] ST_STOPPED = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_LAP     = 2'd2;

  localparam logic [7:0] MIN_MAX_BCD = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};

  logic [1:0] r_state;
  logic       r_tick_d;
  logic [7:0] r_cs, r_sec, r_min;
  logic [7:0] r_lap_cs, r_lap_sec, r_lap_min;
  logic       r_rollover;

  logic       w_step;
  logic       w_take;
  logic       w_cs_wrap, w_sec_wrap, w_min_wrap;
  logic [7:0] w_inc_cs, w_inc_sec, w_inc_min;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic wrap);
    logic [7:0] r;
    if (wrap)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign w_step = (EDGE_MODE != 0) ? (i_base_tick ^ r_tick_d) : (i_base_tick & ~r_tick_d);
  assign w_take = w_step && (r_state != ST_STOPPED) && !i_clear;

  assign w_cs_wrap  = (r_cs == 8'h99);
  assign w_sec_wrap = (r_sec == 8'h59);
  assign w_min_wrap = (r_min == MIN_MAX_BCD);

  assign w_inc_cs  = bcd_inc(r_cs, w_cs_wrap);
  assign w_inc_sec = w_cs_wrap ? bcd_inc(r_sec, w_sec_wrap) : r_sec;
  assign w_inc_min = (w_cs_wrap && w_sec_wrap) ? bcd_inc(r_min, w_min_wrap) : r_min;

  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_STOPPED;
      r_tick_d   <= 1'b0;
      r_cs       <= 8'h00;
      r_sec      <= 8'h00;
      r_min      <= 8'h00;
      r_lap_cs   <= 8'h00;
      r_lap_sec  <= 8'h00;
      r_lap_min  <= 8'h00;
      r_rollover <= 1'b0;
    end else begin
      r_tick_d <= i_base_tick;
      if (i_clear) begin
        r_state    <= ST_STOPPED;
        r_cs       <= 8'h00;
        r_sec      <= 8'h00;
        r_min      <= 8'h00;
        r_lap_cs   <= 8'h00;
        r_lap_sec  <= 8'h00;
        r_lap_min  <= 8'h00;
        r_rollover <= 1'b0;
      end else begin
        r_rollover <= w_take && w_cs_wrap && w_sec_wrap && w_min_wrap;
        if (w_take) begin
          r_cs  <= w_inc_cs;
          r_sec <= w_inc_sec;
          r_min <= w_inc_min;
        end
        case (r_state)
          ST_STOPPED: if (i_start_stop) r_state <= ST_RUNNING;
          ST_RUNNING: begin
            if (i_start_stop) begin
              r_state <= ST_STOPPED;
            end else if (i_lap) begin
              // Freeze the count the user was looking at when lap was pressed.
              r_state   <= ST_LAP;
              r_lap_cs  <= r_cs;
              r_lap_sec <= r_sec;
              r_lap_min <= r_min;
            end
          end
          ST_LAP: begin
            if (i_start_stop)
              r_state <= ST_STOPPED;
            else if (i_lap)
              r_state <= ST_RUNNING;
          end
          default: r_state <= ST_STOPPED;
        endcase
      end
    end
  end

  assign o_running    = (r_state != ST_STOPPED);
  assign o_timerenb   = o_running;
  assign o_lap_active = (r_state == ST_LAP);
  assign o_rollover   = r_rollover;
  assign o_cs_bcd     = o_lap_active ? r_lap_cs  : r_cs;
  assign o_sec_bcd    = o_lap_active ? r_lap_sec : r_sec;
  assign o_min_bcd    = o_lap_active ? r_lap_min : r_min;

endmodule
